// File: rtl/program_loader_if.sv
// Stream-input and memory-write-port bundle for program_loader.
// The slave modport is the loader's view. The master modport is the host/memory side.
interface program_loader_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  modport master (
    output in_valid, in_data,
    input  in_ready, mem_wr, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_wr, mem_addr, mem_wdata
  );
endinterface

// File: rtl/program_loader.sv
// Boot loader: writes a LEN/data/CSUM framed image into program memory and then releases the CPU reset.
// Optional: PROGRAM_LOADER_CHECKSUM_EN enables the trailing checksum byte and its check.
module program_loader #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  program_loader_if.slave     bus,
  output logic                cpu_rst,
  output logic                done,
  output logic                error
);

  typedef enum logic [2:0] {
    IDLE, LEN, DATA, CSUM, FLUSH, RUN, ERR
  } state_t;

  localparam logic [DATA_W-1:0] DEPTH_B = DATA_W'(DEPTH);

  state_t            state_q, state_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [DATA_W-1:0] sum_q, sum_d;
  logic              mem_wr_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_d;
  logic              accept;
  logic              last_byte;

  assign accept    = bus.in_valid && bus.in_ready;
  assign last_byte = (count_q == len_q - 1'b1);

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    count_d     = count_q;
    sum_d       = sum_q;
    mem_wr_d    = 1'b0;
    mem_addr_d  = bus.mem_addr;
    mem_wdata_d = bus.mem_wdata;
    case (state_q)
      IDLE: begin
        count_d = '0;
        sum_d   = '0;
        if (start) state_d = LEN;
      end
      LEN: begin
        if (accept) begin
          if ((bus.in_data == '0) || (bus.in_data > DEPTH_B)) begin
            state_d = ERR;
          end else begin
            len_d   = bus.in_data[ADDR_W:0];
            count_d = '0;
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (accept) begin
          mem_wr_d    = 1'b1;
          mem_addr_d  = count_q[ADDR_W-1:0];
          mem_wdata_d = bus.in_data;
          sum_d       = sum_q + bus.in_data;
          count_d     = count_q + 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          if (last_byte) state_d = CSUM;
`else
          if (last_byte) state_d = FLUSH;
`endif
        end
      end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      CSUM: begin
        if (accept) state_d = (bus.in_data == sum_q) ? RUN : ERR;
      end
`endif
      // FLUSH lets the final write strobe land before cpu_rst is released.
      FLUSH: state_d = RUN;
      RUN, ERR: begin
        if (start) begin
          count_d = '0;
          sum_d   = '0;
          state_d = LEN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      len_q         <= '0;
      count_q       <= '0;
      sum_q         <= '0;
      bus.in_ready  <= 1'b0;
      bus.mem_wr    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      cpu_rst       <= 1'b1;
      done          <= 1'b0;
      error         <= 1'b0;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      count_q       <= count_d;
      sum_q         <= sum_d;
      bus.mem_wr    <= mem_wr_d;
      bus.mem_addr  <= mem_addr_d;
      bus.mem_wdata <= mem_wdata_d;
      // Status outputs are decoded from the next state so they are registered yet track the state.
      bus.in_ready  <= (state_d == LEN) || (state_d == DATA) || (state_d == CSUM);
      cpu_rst       <= (state_d != RUN);
      done          <= (state_d == RUN);
      error         <= (state_d == ERR);
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed self-checking bench for program_loader; follows PROGRAM_LOADER_CHECKSUM_EN for frame format.
module tb_program_loader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic cpu_rst, done, error;

  int tests = 0;
  int fails = 0;

  logic [4:0] wa[$];
  logic [7:0] wd[$];
  logic [7:0] exp_q[$];
  logic [7:0] model [32];

  program_loader_if #(.ADDR_W(5), .DATA_W(8)) bus ();

  program_loader #(.ADDR_W(5), .DATA_W(8), .DEPTH(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .bus     (bus),
    .cpu_rst (cpu_rst),
    .done    (done),
    .error   (error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.mem_wr === 1'b1) begin
      wa.push_back(bus.mem_addr);
      wd.push_back(bus.mem_wdata);
      model[bus.mem_addr] = bus.mem_wdata;
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    int n;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 16) begin
      tick();
      n++;
    end
    chk("in_ready_for_byte", bus.in_ready, 1);
    tick();
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_in_ready", bus.in_ready, 1);
    chk("start_cpu_rst", cpu_rst, 1);
    chk("start_done", done, 0);
    chk("start_error", error, 0);
  endtask

  task automatic finish_frame(input logic [7:0] cs);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    send(cs);
    bus.in_valid = 1'b0;
    chk("run_done", done, 1);
    chk("run_cpu_rst", cpu_rst, 0);
`else
    $display("[TB] frame end, checksum %02h not sent in this build", cs);
    bus.in_valid = 1'b0;
    chk("flush_done", done, 0);
    chk("flush_cpu_rst", cpu_rst, 1);
    tick();
    chk("run_done", done, 1);
    chk("run_cpu_rst", cpu_rst, 0);
`endif
  endtask

  task automatic check_writes(input string tag);
    tick();
    chk({tag, "_count"}, wa.size(), exp_q.size());
    for (int i = 0; i < wa.size() && i < exp_q.size(); i++) begin
      chk({tag, "_addr"}, wa[i], i);
      chk({tag, "_data"}, wd[i], exp_q[i]);
    end
    wa.delete();
    wd.delete();
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    tick();
    tick();
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_mem_wr", bus.mem_wr, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_cpu_rst", cpu_rst, 1);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    rst = 1'b0;
    tick();
    chk("idle_in_ready", bus.in_ready, 0);

    // Good load, back-to-back bytes
    do_start();
    wa.delete(); wd.delete();
    send(8'h03);
    send(8'h21);
    chk("t1_strobe0", bus.mem_wr, 1);
    send(8'h42);
    send(8'hE0);
    chk("t1_strobe2_addr", bus.mem_addr, 2);
    finish_frame(8'h43);
    exp_q = '{8'h21, 8'h42, 8'hE0};
    check_writes("t1");

    // Reload while running: overwrites from address 0
    do_start();
    send(8'h02);
    send(8'h5A);
    send(8'hA5);
    finish_frame(8'hFF);
    exp_q = '{8'h5A, 8'hA5};
    check_writes("t6");
    chk("t6_mem2_kept", model[2], 8'hE0);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    // Bad checksum
    do_start();
    send(8'h03);
    send(8'h21);
    send(8'h42);
    send(8'hE0);
    send(8'h44);
    bus.in_valid = 1'b0;
    chk("t2_error", error, 1);
    chk("t2_cpu_rst", cpu_rst, 1);
    chk("t2_done", done, 0);
    chk("t2_in_ready", bus.in_ready, 0);
    exp_q = '{8'h21, 8'h42, 8'hE0};
    check_writes("t2");
    chk("t2_error_held", error, 1);
`endif

    // LEN = 0 rejected
    do_start();
    send(8'h00);
    bus.in_valid = 1'b0;
    chk("t3_len0_error", error, 1);
    chk("t3_len0_in_ready", bus.in_ready, 0);
    chk("t3_len0_cpu_rst", cpu_rst, 1);
    exp_q.delete();
    check_writes("t3_len0");

    // LEN = 33 rejected
    do_start();
    send(8'h21);
    bus.in_valid = 1'b0;
    chk("t3_len33_error", error, 1);
    exp_q.delete();
    check_writes("t3_len33");

    // LEN = 32, full memory
    do_start();
    send(8'h20);
    exp_q.delete();
    for (int i = 0; i < 32; i++) begin
      send(8'(i));
      exp_q.push_back(8'(i));
    end
    finish_frame(8'hF0);
    check_writes("t3_full");

    // Handshake gaps: valid 1,0,0,1
    do_start();
    send(8'h02);
    send(8'h11);
    chk("t4_strobe_a", bus.mem_wr, 1);
    chk("t4_addr_a", bus.mem_addr, 0);
    bus.in_valid = 1'b0;
    tick();
    chk("t4_gap1_wr", bus.mem_wr, 0);
    chk("t4_gap1_ready", bus.in_ready, 1);
    tick();
    chk("t4_gap2_wr", bus.mem_wr, 0);
    chk("t4_gap2_ready", bus.in_ready, 1);
    chk("t4_gap2_wdata", bus.mem_wdata, 8'h11);
    send(8'h22);
    chk("t4_strobe_b", bus.mem_wr, 1);
    chk("t4_addr_b", bus.mem_addr, 1);
    finish_frame(8'h33);
    exp_q = '{8'h11, 8'h22};
    check_writes("t4");

    // Reset mid-load after 2 of 4 data bytes; third byte offered at the reset edge
    do_start();
    send(8'h04);
    send(8'h01);
    send(8'h02);
    bus.in_data = 8'h03;
    rst = 1'b1;
    tick();
    chk("t5_in_ready", bus.in_ready, 0);
    chk("t5_cpu_rst", cpu_rst, 1);
    chk("t5_mem_wr", bus.mem_wr, 0);
    chk("t5_mem_addr", bus.mem_addr, 0);
    chk("t5_done", done, 0);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    tick();
    chk("t5_idle_ready", bus.in_ready, 0);
    exp_q = '{8'h01, 8'h02};
    check_writes("t5_abort");
    chk("t5_mem3_kept", model[3], 8'h03);
    do_start();
    send(8'h03);
    send(8'h07);
    send(8'h08);
    send(8'h09);
    finish_frame(8'h18);
    exp_q = '{8'h07, 8'h08, 8'h09};
    check_writes("t5_reload");
    chk("t5_mem31_kept", model[31], 8'h1F);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Boot-time loader upstream of the CPU's 32x8 program memory.
- Receives a framed byte stream over a valid/ready handshake and writes it into memory from address 0.
- Holds the CPU in reset until a complete, checksum-verified image has been written, then releases it.
- Sits between the host byte source and the memory write port / CPU reset input.

Parameters:
- ADDR_W, 5, memory address width.
- DATA_W, 8, memory word and stream byte width.
- DEPTH, 32, maximum image length in words (must equal 2**ADDR_W).

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- start  input  1  single-cycle request to begin a load
- in_valid  input  1  stream byte valid
- in_data  input  DATA_W  stream byte
- in_ready  output  1  loader accepts a byte this cycle
- mem_wr  output  1  memory write strobe
- mem_addr  output  ADDR_W  memory write address
- mem_wdata  output  DATA_W  memory write data
- cpu_rst  output  1  reset to CPU; high holds it
- done  output  1  image loaded, CPU running
- error  output  1  load failed

Behaviour:
- Clock and reset: reset rst, synchronous, active-high; clock clk.
- Reset values: state=IDLE, cpu_rst=1, in_ready=0, mem_wr=0, mem_addr=0, mem_wdata=0, done=0, error=0; internal len, count and sum = 0.
- All outputs are registered.
- Frame format: LEN byte, then LEN data bytes, then CSUM byte.
  - CSUM = sum of the data bytes mod 256.
- A byte is accepted when in_valid && in_ready are both high at a rising edge. At most one byte is accepted per cycle.
- in_ready is high exactly while the state is LEN, DATA or CSUM.
- IDLE:
  - start=1 -> LEN.
  - Clears count, sum and error.
- LEN, on accept:
  - Value 0 or value > DEPTH -> ERR.
  - Otherwise latch len, count=0 -> DATA.
- DATA, on each accept:
  - Next cycle: mem_wr=1 for exactly one cycle, mem_addr=count, mem_wdata=byte.
  - sum = sum + byte (mod 256); count++.
  - When the accepted byte is number len -> CSUM.
  - count never exceeds len-1 as an address, so there is no wrap past DEPTH-1.
- CSUM, on accept:
  - byte == sum -> RUN.
  - Otherwise -> ERR.
- RUN:
  - cpu_rst=0 and done=1 from the first cycle in RUN.
  - Equivalently, one cycle after CSUM acceptance.
- ERR:
  - error=1, cpu_rst=1, done=0, in_ready=0.
  - Held until start or rst.
- start while in RUN or ERR -> LEN, with these effects on the next cycle: cpu_rst=1, done=0, error=0, count and sum cleared.
- start while in LEN, DATA or CSUM is ignored.
- in_valid=0 gaps are allowed anywhere. Outputs hold; mem_wr=0 during gaps.
- rst mid-load:
  - Immediate return to reset values; any write strobe pending from the previous cycle is dropped.
  - Memory contents already written are not cleared.

Optional Feature:
- Macro: PROGRAM_LOADER_CHECKSUM_EN.
- Defined: CSUM state and check behave as described above.
- Undefined:
  - No CSUM byte is expected; DATA goes to RUN after the last data byte.
  - RUN is entered two cycles after the last data byte is accepted, so the final mem_wr commits before cpu_rst falls.
  - Mismatch-to-ERR path is absent; ERR is reachable only via a bad LEN.

Test Plan:
1. Good load (checksum enabled): start, then 0x03, 0x21, 0x42, 0xE0, 0x43 streamed back-to-back.
   - Required: mem_wr pulses at addr 0,1,2 with data 0x21,0x42,0xE0.
   - Required: done=1 and cpu_rst=0 one cycle after the 0x43 byte is accepted.
2. Bad checksum: same frame with CSUM 0x44.
   - Required: error=1, cpu_rst stays 1, done=0, in_ready=0.
   - Required: a following start clears error and accepts a new LEN.
3. LEN bounds:
   - LEN=0x00 -> ERR, no mem_wr.
   - LEN=0x21 -> ERR, no mem_wr.
   - LEN=0x20 with 32 continuous bytes 0x00..0x1F plus CSUM 0xF0 -> 32 writes at addr 0..31, done=1.
4. Handshake gaps: LEN=2 with in_valid toggling 1,0,0,1.
   - Required: exactly two mem_wr pulses at addr 0,1.
   - Required: no strobe during gaps; in_ready stays 1.
5. Reset mid-load: rst asserted after 2 of 4 data bytes.
   - Required: next cycle state IDLE, cpu_rst=1, in_ready=0, no further mem_wr.
   - Required: a new start plus a full frame completes normally.
6. Reload while running: start in RUN.
   - Required next cycle: cpu_rst=1, done=0, in_ready=1.
   - Required: a new frame overwrites memory from addr 0.
